ula_controle: RTL and testbench
===============================

// Module: ula_controle
// PURPOSE
//  Issue-side counterpart of the ULA: decodes opcode/funct into the 5-bit ULA control code,
//  drives ULA operands, and tracks the ULA's one-clock registered latency. Captures saida,
//  zero and overflow into a held result. Sits between instruction decode and the ULA.
//  valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W     32     operand/result width
//  CTRL_W     5      ULA control code width
//  HOLD_CODE  5'd31  code driven when idle (ULA default branch holds its outputs)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operation request
//  in_ready   out  1       request accepted when in_valid & in_ready at posedge clk
//  in_opcode  in   6       0=R-type,1=addi,2=subi,8=beq,9=bne,10=bgt,11=blt,30=pass-B
//  in_funct   in   6       R-type: 0 add,1 sub,2 mult,3 div,4 and,5 or,6 nand,7 nor,12 slt,13 sle,14 sge
//  in_a/in_b  in   DATA_W  operands
//  alu_ctrl   out  CTRL_W  to ULA controle
//  alu_a/alu_b out DATA_W  to ULA A/B
//  alu_saida  in   DATA_W  from ULA saida; alu_zero, alu_ovf in 1 from ULA zero/overflow
//  res_valid  out  1       result held until res_valid & res_ready
//  res_ready  in   1
//  res_data   out  DATA_W  captured saida (0 on err)
//  res_branch out  1       alu_zero captured for codes 8..11, else 0
//  res_ovf    out  1       captured alu_ovf
//  res_err    out  1       illegal opcode/funct (or div-by-zero trap)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; res_valid=0; res_data=0; res_branch/ovf/err=0;
//   alu_ctrl=HOLD_CODE; alu_a=alu_b=0.
//  FSM: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
//  IDLE: in_ready=1; on accept, decode, latch code/operands -> ISSUE; illegal -> DONE, err=1.
//  ISSUE: in_ready=0; alu_ctrl=decoded code, alu_a/alu_b=latched; ULA samples at this edge -> CAPTURE.
//  CAPTURE: alu_ctrl back to HOLD_CODE; latch saida/zero/ovf into res_* -> DONE.
//  DONE: res_valid=1, res_* stable; on res_ready -> IDLE, res_valid=0 next cycle.
//  Latency: accept at edge E0 -> res_valid high in cycle after E2 (3 clocks). No overlap: 1 op max.
//  res_ready held high in DONE: back-to-back issue at best every 4 clocks (accept in IDLE only).
//  in_valid while busy: ignored (in_ready=0); requester must hold.
//  Illegal encodings: no ULA issue, alu_ctrl stays HOLD_CODE, res_data=0, err=1.
//  addi/subi use in_b as provided immediate (sign extension upstream).
//  rst in any state: return to reset values next edge; in-flight result discarded.
// CONFIGURATION
//  ULA_DIV0_TRAP_EN defined: R-type div with in_b==0 -> treated as illegal (DONE, err=1, no issue).
//  Undefined: div by zero issued to ULA unchanged; res_data is whatever ULA returns, err=0.
// STRUCTURE
//  ula_pkg: localparams for ULA codes (ADD=0..SGE=14, PASS_B=30, HOLD=31), opcode/funct
//   values, FSM state encoding.
//  Sub-module ula_decode (combinational): opcode,funct -> ctrl code, legal, is_branch.
// TESTING
//  R add: a=5,b=7,funct 0 -> alu_ctrl=0 in ISSUE; res_data=12, err=0, 3 clocks after accept.
//  beq a=b=9 -> res_branch=1; bne a=b=9 -> res_branch=0; blt a=3,b=4 -> res_branch=1.
//  mult a=b=32'h0001_0000 -> res_ovf=1 captured; res_data=ULA product.
//  opcode 5 -> res_err=1, res_data=0, alu_ctrl never leaves 31.
//  div b=0: with ULA_DIV0_TRAP_EN err=1, no issue; without, alu_ctrl=3 issued, err=0.
//  res_ready low 10 cycles in DONE -> res_* stable, in_ready=0; rst in CAPTURE -> IDLE, res_valid=0.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared ULA control codes, opcode/funct encodings and issue FSM states
package ula_pkg;

    localparam int CTRL_CODE_W = 5;

    // ULA control codes
    localparam logic [4:0] ULA_ADD    = 5'd0;
    localparam logic [4:0] ULA_SUB    = 5'd1;
    localparam logic [4:0] ULA_MULT   = 5'd2;
    localparam logic [4:0] ULA_DIV    = 5'd3;
    localparam logic [4:0] ULA_AND    = 5'd4;
    localparam logic [4:0] ULA_OR     = 5'd5;
    localparam logic [4:0] ULA_NAND   = 5'd6;
    localparam logic [4:0] ULA_NOR    = 5'd7;
    localparam logic [4:0] ULA_BEQ    = 5'd8;
    localparam logic [4:0] ULA_BNE    = 5'd9;
    localparam logic [4:0] ULA_BGT    = 5'd10;
    localparam logic [4:0] ULA_BLT    = 5'd11;
    localparam logic [4:0] ULA_SLT    = 5'd12;
    localparam logic [4:0] ULA_SLE    = 5'd13;
    localparam logic [4:0] ULA_SGE    = 5'd14;
    localparam logic [4:0] ULA_PASS_B = 5'd30;
    localparam logic [4:0] ULA_HOLD   = 5'd31;

    // Instruction opcodes
    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_ADDI   = 6'd1;
    localparam logic [5:0] OP_SUBI   = 6'd2;
    localparam logic [5:0] OP_BEQ    = 6'd8;
    localparam logic [5:0] OP_BNE    = 6'd9;
    localparam logic [5:0] OP_BGT    = 6'd10;
    localparam logic [5:0] OP_BLT    = 6'd11;
    localparam logic [5:0] OP_PASS_B = 6'd30;

    // R-type funct values
    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_SUB  = 6'd1;
    localparam logic [5:0] FN_MULT = 6'd2;
    localparam logic [5:0] FN_DIV  = 6'd3;
    localparam logic [5:0] FN_AND  = 6'd4;
    localparam logic [5:0] FN_OR   = 6'd5;
    localparam logic [5:0] FN_NAND = 6'd6;
    localparam logic [5:0] FN_NOR  = 6'd7;
    localparam logic [5:0] FN_SLT  = 6'd12;
    localparam logic [5:0] FN_SLE  = 6'd13;
    localparam logic [5:0] FN_SGE  = 6'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Branch codes are the only ones whose zero flag means "condition taken"
    function automatic logic code_is_branch(input logic [4:0] code);
        return (code >= ULA_BEQ) && (code <= ULA_BLT);
    endfunction

endpackage

// File: rtl/ula_decode.sv
// rtl/ula_decode.sv - combinational opcode/funct to ULA control code decoder
module ula_decode
    import ula_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] code,
    output logic       legal,
    output logic       is_branch,
    output logic       is_div
);

    // Map the instruction encoding onto a ULA code; anything unlisted stays HOLD and illegal
    always_comb begin
        code  = ULA_HOLD;
        legal = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                unique case (funct)
                    FN_ADD:  code = ULA_ADD;
                    FN_SUB:  code = ULA_SUB;
                    FN_MULT: code = ULA_MULT;
                    FN_DIV:  code = ULA_DIV;
                    FN_AND:  code = ULA_AND;
                    FN_OR:   code = ULA_OR;
                    FN_NAND: code = ULA_NAND;
                    FN_NOR:  code = ULA_NOR;
                    FN_SLT:  code = ULA_SLT;
                    FN_SLE:  code = ULA_SLE;
                    FN_SGE:  code = ULA_SGE;
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI: begin
                code  = ULA_ADD;
                legal = 1'b1;
            end
            OP_SUBI: begin
                code  = ULA_SUB;
                legal = 1'b1;
            end
            OP_BEQ: begin
                code  = ULA_BEQ;
                legal = 1'b1;
            end
            OP_BNE: begin
                code  = ULA_BNE;
                legal = 1'b1;
            end
            OP_BGT: begin
                code  = ULA_BGT;
                legal = 1'b1;
            end
            OP_BLT: begin
                code  = ULA_BLT;
                legal = 1'b1;
            end
            OP_PASS_B: begin
                code  = ULA_PASS_B;
                legal = 1'b1;
            end
            default: begin
                code  = ULA_HOLD;
                legal = 1'b0;
            end
        endcase
    end

    assign is_branch = legal && code_is_branch(code);
    assign is_div    = legal && (code == ULA_DIV);

endmodule

// File: rtl/ula_controle.sv
// rtl/ula_controle.sv - ULA issue controller, one op in flight, held result; option ULA_DIV0_TRAP_EN
module ula_controle
    import ula_pkg::*;
#(
    parameter int                 DATA_W    = 32,
    parameter int                 CTRL_W    = 5,
    parameter logic [CTRL_W-1:0]  HOLD_CODE = 5'd31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_saida,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_branch,
    output logic              res_ovf,
    output logic              res_err
);

`ifdef ULA_DIV0_TRAP_EN
    localparam bit DIV0_TRAP = 1'b1;
`else
    localparam bit DIV0_TRAP = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [4:0]          dec_code;
    logic                dec_legal;
    logic                dec_is_branch;
    logic                dec_is_div;
    logic                div_by_zero;
    logic                issue_ok;
    logic                accept;

    logic [CTRL_W-1:0]   code_q;
    logic                branch_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_branch_q;
    logic                res_ovf_q;
    logic                res_err_q;

    ula_decode u_decode (
        .opcode    (in_opcode),
        .funct     (in_funct),
        .code      (dec_code),
        .legal     (dec_legal),
        .is_branch (dec_is_branch),
        .is_div    (dec_is_div)
    );

    // A trapped divide by zero is handled exactly like an illegal encoding
    assign div_by_zero = dec_is_div && (in_b == '0);
    assign issue_ok    = dec_legal && !(DIV0_TRAP && div_by_zero);
    assign accept      = in_valid && (state_q == ST_IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/ULA control outputs; alu_ctrl leaves HOLD only during ISSUE
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        alu_ctrl  = HOLD_CODE;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = issue_ok ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                alu_ctrl = code_q;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the decoded code and operands for a legal op; illegal ops leave the ULA inputs untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= HOLD_CODE;
            branch_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (accept && issue_ok) begin
            code_q   <= CTRL_W'(dec_code);
            branch_q <= dec_is_branch;
            a_q      <= in_a;
            b_q      <= in_b;
        end
    end

    // Result capture: cleared on a legal accept, flagged on an illegal one, loaded from the ULA in CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q   <= '0;
            res_branch_q <= 1'b0;
            res_ovf_q    <= 1'b0;
            res_err_q    <= 1'b0;
        end else if (accept) begin
            res_data_q   <= '0;
            res_branch_q <= 1'b0;
            res_ovf_q    <= 1'b0;
            res_err_q    <= !issue_ok;
        end else if (state_q == ST_CAPTURE) begin
            res_data_q   <= alu_saida;
            res_branch_q <= branch_q && alu_zero;
            res_ovf_q    <= alu_ovf;
            res_err_q    <= 1'b0;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign res_data   = res_data_q;
    assign res_branch = res_branch_q;
    assign res_ovf    = res_ovf_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_ula_controle.sv
// tb/tb_ula_controle.sv - directed scoreboard bench for ula_controle with a registered ULA model
module tb_ula_controle;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_a, in_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [DATA_W-1:0] alu_saida;
    logic              alu_zero, alu_ovf;
    logic              res_valid, res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_branch, res_ovf, res_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] data;
        logic        br;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ula_controle #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .HOLD_CODE(5'd31)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct   (in_funct),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_saida  (alu_saida),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_branch (res_branch),
        .res_ovf    (res_ovf),
        .res_err    (res_err)
    );

    // Registered ULA model: computes from ctrl/A/B, holds outputs on unknown codes
    logic [31:0] u_sum, u_diff, u_div, u_s;
    logic [63:0] u_prod;
    logic        u_z, u_o, u_hold;

    always_comb begin
        u_sum  = alu_a + alu_b;
        u_diff = alu_a - alu_b;
        u_prod = 64'($signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b}));
        u_div  = (alu_b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(alu_a) / $signed(alu_b));
        u_s    = 32'd0;
        u_o    = 1'b0;
        u_hold = 1'b0;
        case (alu_ctrl)
            5'd0:  begin u_s = u_sum;  u_o = (alu_a[31] == alu_b[31]) && (u_sum[31] != alu_a[31]); end
            5'd1:  begin u_s = u_diff; u_o = (alu_a[31] != alu_b[31]) && (u_diff[31] != alu_a[31]); end
            5'd2:  begin u_s = u_prod[31:0]; u_o = (u_prod != {{32{u_prod[31]}}, u_prod[31:0]}); end
            5'd3:  u_s = u_div;
            5'd4:  u_s = alu_a & alu_b;
            5'd5:  u_s = alu_a | alu_b;
            5'd6:  u_s = ~(alu_a & alu_b);
            5'd7:  u_s = ~(alu_a | alu_b);
            5'd8, 5'd9, 5'd10, 5'd11: u_s = u_diff;
            5'd12: u_s = {31'd0, $signed(alu_a) <  $signed(alu_b)};
            5'd13: u_s = {31'd0, $signed(alu_a) <= $signed(alu_b)};
            5'd14: u_s = {31'd0, $signed(alu_a) >= $signed(alu_b)};
            5'd30: u_s = alu_b;
            default: u_hold = 1'b1;
        endcase
        case (alu_ctrl)
            5'd8:    u_z = (alu_a == alu_b);
            5'd9:    u_z = (alu_a != alu_b);
            5'd10:   u_z = ($signed(alu_a) > $signed(alu_b));
            5'd11:   u_z = ($signed(alu_a) < $signed(alu_b));
            default: u_z = (u_s == 32'd0);
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            alu_saida <= 32'd0;
            alu_zero  <= 1'b0;
            alu_ovf   <= 1'b0;
        end else if (!u_hold) begin
            alu_saida <= u_s;
            alu_zero  <= u_z;
            alu_ovf   <= u_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: drive, push expectation, follow the FSM, pop and compare, optionally stall res_ready
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ecode, input logic [31:0] edata,
                          input logic ebr, input logic eovf, input logic eerr, input int hold);
        exp_t e, got;
        int   lat;
        int   exp_lat;
        logic ctrl_leak;
        e.code = ecode; e.data = edata; e.br = ebr; e.ovf = eovf; e.err = eerr;
        exp_lat = (ecode == 5'd31) ? 1 : 3;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_opcode = op; in_funct = fn; in_a = a; in_b = b;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        check({tag, "_alu_ctrl_issue"}, 32'(alu_ctrl), 32'(ecode));
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        if (ecode != 5'd31) begin
            check({tag, "_alu_a"}, alu_a, a);
            check({tag, "_alu_b"}, alu_b, b);
        end
        ctrl_leak = 1'b0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (alu_ctrl != 5'd31) ctrl_leak = 1'b1;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ctrl_hold_after_issue"}, 32'(ctrl_leak), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_res_data"},   res_data,          got.data);
            check({tag, "_res_branch"}, 32'(res_branch),   32'(got.br));
            check({tag, "_res_ovf"},    32'(res_ovf),      32'(got.ovf));
            check({tag, "_res_err"},    32'(res_err),      32'(got.err));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; in_opcode = 6'd0; in_funct = 6'd0; in_a = 32'd1; in_b = 32'd1;
                @(negedge clk);
                check({tag, "_hold_res_valid"}, 32'(res_valid), 32'd1);
                check({tag, "_hold_in_ready"},  32'(in_ready),  32'd0);
                check({tag, "_hold_res_data"},  res_data,       got.data);
                check({tag, "_hold_res_err"},   32'(res_err),   32'(got.err));
                check({tag, "_hold_alu_ctrl"},  32'(alu_ctrl),  32'd31);
            end
            in_valid = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opcode = 6'd0; in_funct = 6'd0;
        in_a = 32'd0; in_b = 32'd0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_res_valid",  32'(res_valid),  32'd0);
        check("rst_res_data",   res_data,        32'd0);
        check("rst_res_branch", 32'(res_branch), 32'd0);
        check("rst_res_ovf",    32'(res_ovf),    32'd0);
        check("rst_res_err",    32'(res_err),    32'd0);
        check("rst_alu_ctrl",   32'(alu_ctrl),   32'd31);
        check("rst_alu_a",      alu_a,           32'd0);
        check("rst_alu_b",      alu_b,           32'd0);
        rst = 1'b0;

        //      tag        op     fn     a              b              code   data           br    ovf   err   hold
        run_op("add",      6'd0,  6'd0,  32'd5,         32'd7,         5'd0,  32'd12,        1'b0, 1'b0, 1'b0, 0);
        run_op("beq_eq",   6'd8,  6'd0,  32'd9,         32'd9,         5'd8,  32'd0,         1'b1, 1'b0, 1'b0, 0);
        run_op("bne_eq",   6'd9,  6'd0,  32'd9,         32'd9,         5'd9,  32'd0,         1'b0, 1'b0, 1'b0, 0);
        run_op("blt",      6'd11, 6'd0,  32'd3,         32'd4,         5'd11, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("bgt_no",   6'd10, 6'd0,  32'd3,         32'd4,         5'd10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
        run_op("mult_ovf", 6'd0,  6'd2,  32'h0001_0000, 32'h0001_0000, 5'd2,  32'd0,         1'b0, 1'b1, 1'b0, 0);
        run_op("sub_zero", 6'd0,  6'd1,  32'd5,         32'd5,         5'd1,  32'd0,         1'b0, 1'b0, 1'b0, 0);
        run_op("ill_op5",  6'd5,  6'd0,  32'd1,         32'd2,         5'd31, 32'd0,         1'b0, 1'b0, 1'b1, 0);
`ifdef ULA_DIV0_TRAP_EN
        run_op("div0",     6'd0,  6'd3,  32'd8,         32'd0,         5'd31, 32'd0,         1'b0, 1'b0, 1'b1, 0);
`else
        run_op("div0",     6'd0,  6'd3,  32'd8,         32'd0,         5'd3,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
`endif
        run_op("div",      6'd0,  6'd3,  32'd20,        32'd3,         5'd3,  32'd6,         1'b0, 1'b0, 1'b0, 0);
        run_op("addi",     6'd1,  6'd0,  32'd100,       32'hFFFF_FFFF, 5'd0,  32'd99,        1'b0, 1'b0, 1'b0, 0);
        run_op("subi",     6'd2,  6'd0,  32'd10,        32'd3,         5'd1,  32'd7,         1'b0, 1'b0, 1'b0, 0);
        run_op("pass_b",   6'd30, 6'd0,  32'd1,         32'hDEAD_BEEF, 5'd30, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 0);
        run_op("ill_fn8",  6'd0,  6'd8,  32'd1,         32'd2,         5'd31, 32'd0,         1'b0, 1'b0, 1'b1, 0);
        run_op("slt",      6'd0,  6'd12, 32'd2,         32'd5,         5'd12, 32'd1,         1'b0, 1'b0, 1'b0, 0);
        run_op("add_ovf",  6'd0,  6'd0,  32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0, 0);
        run_op("nor_hold", 6'd0,  6'd7,  32'd0,         32'd0,         5'd7,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 10);

        // Reset while the op sits in CAPTURE: result must be discarded
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 6'd0; in_funct = 6'd0; in_a = 32'd40; in_b = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("rstcap_issue_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstcap_res_valid", 32'(res_valid), 32'd0);
        check("rstcap_in_ready",  32'(in_ready),  32'd1);
        check("rstcap_alu_ctrl",  32'(alu_ctrl),  32'd31);
        check("rstcap_alu_a",     alu_a,          32'd0);
        check("rstcap_res_data",  res_data,       32'd0);
        repeat (3) @(negedge clk);
        check("rstcap_still_idle", 32'(res_valid), 32'd0);

        // Normal operation resumes after the mid-flight reset
        run_op("post_rst", 6'd0,  6'd4,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd4,  32'h00F0_000F, 1'b0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
